// File: rtl/output_credit_ctrl.sv
// rtl/output_credit_ctrl.sv - per-VC credit-based link output stage with 1-cycle registered forwarding
// Optional packet protocol checker: define OUTPUT_CREDIT_CTRL_PROTO_CHK_EN.
module output_credit_ctrl #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 2,
    parameter int N_CREDITS  = 4
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [FLIT_WIDTH-1:0]         fin_fdata_i,
    input  logic                          fin_valid_i,
    input  logic [$clog2(N_VIRT_CHN)-1:0] fin_vc_id_i,
    output logic                          fin_ready_o,
    output logic [FLIT_WIDTH-1:0]         fout_fdata_o,
    output logic                          fout_valid_o,
    output logic [$clog2(N_VIRT_CHN)-1:0] fout_vc_id_o,
    input  logic [N_VIRT_CHN-1:0]         credit_i,
    output logic                          credit_err_o,
    output logic                          proto_err_o
);

    localparam int VC_W  = $clog2(N_VIRT_CHN);
    localparam int CNT_W = $clog2(N_CREDITS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_CREDITS);

    logic [CNT_W-1:0]      credit_q [N_VIRT_CHN];
    logic [CNT_W-1:0]      credit_d [N_VIRT_CHN];
    logic                  credit_err_q, credit_err_d;
    logic [FLIT_WIDTH-1:0] fout_fdata_q, fout_fdata_d;
    logic [VC_W-1:0]       fout_vc_id_q, fout_vc_id_d;
    logic                  fout_valid_q, fout_valid_d;
    logic                  accept;
    logic [N_VIRT_CHN-1:0] take;

    assign fin_ready_o  = (credit_q[fin_vc_id_i] != '0);
    assign fout_fdata_o = fout_fdata_q;
    assign fout_vc_id_o = fout_vc_id_q;
    assign fout_valid_o = fout_valid_q;
    assign credit_err_o = credit_err_q;

    always_comb begin
        accept       = fin_valid_i && fin_ready_o;
        take         = '0;
        credit_err_d = credit_err_q;
        fout_valid_d = accept;
        fout_fdata_d = accept ? fin_fdata_i : fout_fdata_q;
        fout_vc_id_d = accept ? fin_vc_id_i : fout_vc_id_q;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            take[v]     = accept && (fin_vc_id_i == VC_W'(v));
            credit_d[v] = credit_q[v];
            // A consume and a return on the same VC cancel out.
            if (take[v] && !credit_i[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end else if (credit_i[v] && !take[v]) begin
                if (credit_q[v] == FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < N_VIRT_CHN; v++) credit_q[v] <= FULL;
            credit_err_q <= 1'b0;
            fout_valid_q <= 1'b0;
            fout_fdata_q <= '0;
            fout_vc_id_q <= '0;
        end else begin
            for (int v = 0; v < N_VIRT_CHN; v++) credit_q[v] <= credit_d[v];
            credit_err_q <= credit_err_d;
            fout_valid_q <= fout_valid_d;
            fout_fdata_q <= fout_fdata_d;
            fout_vc_id_q <= fout_vc_id_d;
        end
    end

`ifdef OUTPUT_CREDIT_CTRL_PROTO_CHK_EN
    typedef enum logic {IDLE, IN_PKT} pkt_state_e;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;

    pkt_state_e pkt_q [N_VIRT_CHN];
    pkt_state_e pkt_d [N_VIRT_CHN];
    logic       proto_err_q, proto_err_d;
    logic [1:0] flit_type;

    assign proto_err_o = proto_err_q;

    always_comb begin
        flit_type   = fin_fdata_i[FLIT_WIDTH-1 -: 2];
        proto_err_d = proto_err_q;
        for (int v = 0; v < N_VIRT_CHN; v++) begin
            pkt_d[v] = pkt_q[v];
            // Errors are only flagged; the flit is still forwarded and the FSM resyncs.
            if (take[v]) begin
                case (flit_type)
                    T_HEAD: begin
                        if (pkt_q[v] == IN_PKT) proto_err_d = 1'b1;
                        pkt_d[v] = IN_PKT;
                    end
                    T_BODY: begin
                        if (pkt_q[v] == IDLE) proto_err_d = 1'b1;
                    end
                    T_TAIL: begin
                        if (pkt_q[v] == IDLE) proto_err_d = 1'b1;
                        pkt_d[v] = IDLE;
                    end
                    default: begin
                        if (pkt_q[v] == IN_PKT) proto_err_d = 1'b1;
                        pkt_d[v] = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int v = 0; v < N_VIRT_CHN; v++) pkt_q[v] <= IDLE;
            proto_err_q <= 1'b0;
        end else begin
            for (int v = 0; v < N_VIRT_CHN; v++) pkt_q[v] <= pkt_d[v];
            proto_err_q <= proto_err_d;
        end
    end
`else
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_credit_ctrl.sv
// tb/tb_output_credit_ctrl.sv - scoreboard bench for output_credit_ctrl
module tb_output_credit_ctrl;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [33:0] fin_fdata_i = '0;
    logic        fin_valid_i = 1'b0;
    logic        fin_vc_id_i = 1'b0;
    logic        fin_ready_o;
    logic [33:0] fout_fdata_o;
    logic        fout_valid_o;
    logic        fout_vc_id_o;
    logic [1:0]  credit_i = '0;
    logic        credit_err_o;
    logic        proto_err_o;

    typedef struct {
        logic [33:0] d;
        logic        v;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    output_credit_ctrl #(.FLIT_WIDTH(34), .N_VIRT_CHN(2), .N_CREDITS(4)) dut (
        .clk          (clk),
        .arst         (arst),
        .fin_fdata_i  (fin_fdata_i),
        .fin_valid_i  (fin_valid_i),
        .fin_vc_id_i  (fin_vc_id_i),
        .fin_ready_o  (fin_ready_o),
        .fout_fdata_o (fout_fdata_o),
        .fout_valid_o (fout_valid_o),
        .fout_vc_id_o (fout_vc_id_o),
        .credit_i     (credit_i),
        .credit_err_o (credit_err_o),
        .proto_err_o  (proto_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected flit, including its cycle.
    always @(negedge clk) begin
        if (!arst && fout_valid_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got data %0h vc %0d expected none", fout_fdata_o, fout_vc_id_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 64'(fout_fdata_o), 64'(e.d));
                chk("out_vc", 64'(fout_vc_id_o), 64'(e.v));
                chk("out_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic vc, input logic [1:0] ty, input logic [31:0] pay, input logic exp_rdy);
        exp_t e;
        fin_valid_i = 1'b1;
        fin_vc_id_i = vc;
        fin_fdata_i = {ty, pay};
        #1;
        chk($sformatf("ready_vc%0d_%0h", vc, pay), 64'(fin_ready_o), 64'(exp_rdy));
        if (exp_rdy) begin
            e.d = {ty, pay};
            e.v = vc;
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        fin_valid_i = 1'b0;
        credit_i = '0;
    endtask

    task automatic pulse(input logic [1:0] cr);
        credit_i = cr;
        tick();
        credit_i = '0;
    endtask

    task automatic check_ready(input logic vc, input logic exp);
        fin_vc_id_i = vc;
        #1;
        chk($sformatf("idle_ready_vc%0d", vc), 64'(fin_ready_o), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        arst = 1'b0;
        repeat (5) tick();
        check_ready(1'b0, 1'b1);
        check_ready(1'b1, 1'b1);
        chk("rst_valid", 64'(fout_valid_o), 64'd0);
        chk("rst_data", 64'(fout_fdata_o), 64'd0);
        chk("rst_credit_err", 64'(credit_err_o), 64'd0);
        chk("rst_proto_err", 64'(proto_err_o), 64'd0);

        for (int i = 1; i <= 4; i++) send(1'b0, 2'b11, 32'(i), 1'b1);
        send(1'b0, 2'b11, 32'h5, 1'b0);
        send(1'b1, 2'b11, 32'hA, 1'b1);

        check_ready(1'b0, 1'b0);
        pulse(2'b01);
        chk("hold_valid", 64'(fout_valid_o), 64'd0);
        chk("hold_data", 64'(fout_fdata_o), 64'({2'b11, 32'hA}));
        chk("hold_vc", 64'(fout_vc_id_o), 64'd1);
        check_ready(1'b0, 1'b1);
        send(1'b0, 2'b11, 32'h5, 1'b1);

        send(1'b1, 2'b11, 32'hB, 1'b1);
        credit_i = 2'b10;
        send(1'b1, 2'b11, 32'hC, 1'b1);
        send(1'b1, 2'b11, 32'hD, 1'b1);
        send(1'b1, 2'b11, 32'hE, 1'b1);
        send(1'b1, 2'b11, 32'hF, 1'b0);
        chk("same_cycle_no_err", 64'(credit_err_o), 64'd0);

        check_ready(1'b0, 1'b0);
        repeat (4) pulse(2'b11);
        check_ready(1'b0, 1'b1);
        check_ready(1'b1, 1'b1);
        chk("full_no_err", 64'(credit_err_o), 64'd0);
        pulse(2'b10);
        chk("overflow_err", 64'(credit_err_o), 64'd1);
        repeat (3) tick();
        chk("overflow_sticky", 64'(credit_err_o), 64'd1);
        for (int i = 0; i < 4; i++) send(1'b1, 2'b11, 32'h20 + 32'(i), 1'b1);
        send(1'b1, 2'b11, 32'h24, 1'b0);

        tick();
        arst = 1'b1;
        fin_valid_i = 1'b1;
        fin_vc_id_i = 1'b0;
        fin_fdata_i = {2'b11, 32'h77};
        tick();
        fin_valid_i = 1'b0;
        arst = 1'b0;
        chk("post_rst_valid", 64'(fout_valid_o), 64'd0);
        chk("post_rst_credit_err", 64'(credit_err_o), 64'd0);
        check_ready(1'b1, 1'b1);

        send(1'b0, 2'b01, 32'h55, 1'b1);
`ifdef OUTPUT_CREDIT_CTRL_PROTO_CHK_EN
        chk("proto_err_body", 64'(proto_err_o), 64'd1);
`else
        chk("proto_err_body", 64'(proto_err_o), 64'd0);
`endif
        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
